// File: rtl/mining_ctrl_pkg.sv
// Shared types and constants for the mining job controller.
package mining_ctrl_pkg;

  typedef enum logic [2:0] {
    REQ_JOB  = 3'd0,
    RECV     = 3'd1,
    DISPATCH = 3'd2,
    MINING   = 3'd3,
    SEND     = 3'd4
  } state_e;

  localparam int JOB_BYTES    = 44;
  localparam int RESULT_BYTES = 5;

  localparam logic [7:0] STATUS_FOUND     = 8'hA5;
  localparam logic [7:0] STATUS_EXHAUSTED = 8'h5A;

endpackage

// File: rtl/mining_job_controller_result_serializer.sv
// Shifts out the 5-byte result frame (status, nonce MSB..LSB) over valid/ready.
module result_serializer
  import mining_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  status,
  input  logic [31:0] nonce,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        frame_done
);

  logic [8*RESULT_BYTES-1:0] frame_q, frame_d;
  logic [2:0]                idx_q, idx_d;
  logic                      valid_q, valid_d;

  // Frame, byte index and valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Load a new frame or advance by one byte on each accepted transfer.
  always_comb begin
    frame_d    = frame_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    frame_done = valid_q && tx_ready && (idx_q == 3'(RESULT_BYTES - 1));
    if (load) begin
      frame_d = {status, nonce};
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      if (frame_done) begin
        valid_d = 1'b0;
      end else begin
        frame_d = frame_q << 8;
        idx_d   = idx_q + 3'd1;
      end
    end
  end

  // Current byte is always the top of the shift register.
  always_comb begin
    tx_valid = valid_q;
    tx_byte  = frame_q[8*RESULT_BYTES-1 -: 8];
  end

endmodule

// File: rtl/mining_job_controller.sv
// Receives a 44-byte job, starts the nonce cores, collects the first result
// and returns it as a 5-byte frame.
module mining_job_controller
  import mining_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned RX_TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_abort,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_byte,
  output logic                    request_job,
  output logic [255:0]            job_midstate,
  output logic [95:0]             job_tail,
  output logic                    core_start,
  output logic                    core_stop,
  output logic [NUM_CORES*32-1:0] core_nonce_base,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [2:0]              current_fsm_state
);

  state_e                   state_q, state_d;
  logic [8*JOB_BYTES-1:0]   job_q, job_d;
  logic [5:0]               count_q, count_d;
  logic [NUM_CORES-1:0]     mask_q, mask_d;
  logic [31:0]              idle_q, idle_d;
  logic                     core_stop_q, core_stop_d;

  logic                     found_any;
  logic [31:0]              found_nonce;
  logic [NUM_CORES-1:0]     mask_or;
  logic                     timeout;
  logic                     load;
  logic [7:0]               load_status;
  logic [31:0]              load_nonce;
  logic                     frame_done;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ_JOB;
      job_q       <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      idle_q      <= '0;
      core_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      idle_q      <= idle_d;
      core_stop_q <= core_stop_d;
    end
  end

  // Lowest-index core reporting a find wins.
  always_comb begin
    found_any   = 1'b0;
    found_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (core_found[i] && !found_any) begin
        found_any   = 1'b1;
        found_nonce = core_nonce[i*32 +: 32];
      end
    end
  end

  // Inter-byte gap watchdog; fires on the RX_TIMEOUT-th consecutive idle cycle.
  always_comb begin
    timeout = (RX_TIMEOUT != 0) && !rx_valid && (idle_q == 32'(RX_TIMEOUT) - 32'd1);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    count_d     = count_q;
    mask_d      = mask_q;
    idle_d      = '0;
    core_stop_d = 1'b0;
    load        = 1'b0;
    load_status = STATUS_FOUND;
    load_nonce  = '0;
    mask_or     = mask_q | core_done;
    case (state_q)
      REQ_JOB: begin
        if (rx_valid) begin
          job_d[8*JOB_BYTES-1 -: 8] = rx_byte;
          count_d = 6'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_abort || timeout) begin
          count_d = '0;
          state_d = REQ_JOB;
        end else if (rx_valid) begin
          job_d[(JOB_BYTES - 1 - int'(count_q))*8 +: 8] = rx_byte;
          if (count_q == 6'(JOB_BYTES - 1)) begin
            count_d = '0;
            state_d = DISPATCH;
          end else begin
            count_d = count_q + 6'd1;
          end
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      DISPATCH: begin
        mask_d  = '0;
        state_d = MINING;
      end
      MINING: begin
        // Found beats exhaustion, which beats a host preempt.
        if (found_any) begin
          load        = 1'b1;
          load_status = STATUS_FOUND;
          load_nonce  = found_nonce;
          core_stop_d = 1'b1;
          state_d     = SEND;
        end else if (&mask_or) begin
          mask_d      = mask_or;
          load        = 1'b1;
          load_status = STATUS_EXHAUSTED;
          state_d     = SEND;
        end else begin
          mask_d = mask_or;
          if (rx_valid) begin
            core_stop_d = 1'b1;
            job_d[8*JOB_BYTES-1 -: 8] = rx_byte;
            count_d = 6'd1;
            state_d = RECV;
          end
        end
      end
      SEND: begin
        if (frame_done) state_d = REQ_JOB;
      end
      default: state_d = REQ_JOB;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    request_job       = (state_q == REQ_JOB);
    core_start        = (state_q == DISPATCH);
    core_stop         = core_stop_q;
    current_fsm_state = state_q;
    job_midstate      = job_q[8*JOB_BYTES-1 -: 256];
    job_tail          = job_q[95:0];
  end

  // Each core gets an equal, disjoint slice of the 32-bit nonce space.
  always_comb begin
    core_nonce_base = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_nonce_base[i*32 +: 32] = 32'((64'(i) << 32) / 64'(NUM_CORES));
    end
  end

  result_serializer u_result_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .status     (load_status),
    .nonce      (load_nonce),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_byte    (tx_byte),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_mining_job_controller.sv
// Self-checking bench for mining_job_controller (NUM_CORES=4, RX_TIMEOUT=8).
module tb_mining_job_controller;

  localparam int NC = 4;
  localparam int TO = 8;

  logic           clk;
  logic           rst_n;
  logic           rx_valid;
  logic [7:0]     rx_byte;
  logic           rx_abort;
  logic           tx_valid;
  logic           tx_ready;
  logic [7:0]     tx_byte;
  logic           request_job;
  logic [255:0]   job_midstate;
  logic [95:0]    job_tail;
  logic           core_start;
  logic           core_stop;
  logic [NC*32-1:0] core_nonce_base;
  logic [NC-1:0]  core_found;
  logic [NC*32-1:0] core_nonce;
  logic [NC-1:0]  core_done;
  logic [2:0]     current_fsm_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] job_m [44];

  mining_job_controller #(.NUM_CORES(NC), .RX_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_valid          (rx_valid),
    .rx_byte           (rx_byte),
    .rx_abort          (rx_abort),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_byte           (tx_byte),
    .request_job       (request_job),
    .job_midstate      (job_midstate),
    .job_tail          (job_tail),
    .core_start        (core_start),
    .core_stop         (core_stop),
    .core_nonce_base   (core_nonce_base),
    .core_found        (core_found),
    .core_nonce        (core_nonce),
    .core_done         (core_done),
    .current_fsm_state (current_fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Job bytes in host order form one big-endian 352-bit word.
  function automatic logic [351:0] job_flat();
    logic [351:0] r = '0;
    for (int k = 0; k < 44; k++) r = {r[343:0], job_m[k]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends job bytes first..43 back to back and checks the dispatch pulse.
  task automatic load_job(input int first, input bit seq);
    logic [7:0] b;
    for (int k = first; k < 44; k++) begin
      b = seq ? 8'(k) : 8'($urandom);
      job_m[k] = b;
      send_byte(b);
      if (k == 42) begin
        checks++;
        if (core_start !== 1'b0 || current_fsm_state !== 3'd1)
          $display("FAIL pre_last_byte: start=%b state=%0d, want start=0 state=1", core_start, current_fsm_state);
      end
    end
    checks++;
    if (core_start !== 1'b1 || current_fsm_state !== 3'd2) begin
      errors++;
      $display("FAIL dispatch_pulse: start=%b state=%0d, want start=1 state=2", core_start, current_fsm_state);
    end
    tick();
    checks++;
    if (core_start !== 1'b0 || current_fsm_state !== 3'd3) begin
      errors++;
      $display("FAIL mining_entry: start=%b state=%0d, want start=0 state=3", core_start, current_fsm_state);
    end
    checks++;
    if ({job_midstate, job_tail} !== job_flat()) begin
      errors++;
      $display("FAIL job_contents: got %h want %h", {job_midstate, job_tail}, job_flat());
    end
  endtask

  // Drains a frame and compares every transferred byte with the expected frame.
  task automatic recv_frame(input logic [39:0] exp_frame, input bit rand_ready);
    int n = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    logic [7:0] eb;
    while (n < 5 && cyc < 100) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        checks++;
        if (tx_byte !== prev_byte) begin
          errors++;
          $display("FAIL tx_hold: got %h want %h", tx_byte, prev_byte);
        end
      end
      if (tx_valid && tx_ready) begin
        eb = exp_frame[39 - 8*n -: 8];
        checks++;
        if (tx_byte !== eb) begin
          errors++;
          $display("FAIL tx_byte[%0d]: got %h want %h", n, tx_byte, eb);
        end
        n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL frame_count: got %0d transfers want 5", n);
    end
    if (!rand_ready) begin
      checks++;
      if (cyc != 5) begin
        errors++;
        $display("FAIL frame_cycles: got %0d want 5", cyc);
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || request_job !== 1'b1 || current_fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL frame_end: valid=%b req=%b state=%0d want 0 1 0", tx_valid, request_job, current_fsm_state);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL extra_transfer: tx_valid=%b want 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_base;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (request_job !== 1'b1 || current_fsm_state !== 3'd0 || tx_valid !== 1'b0 ||
        tx_byte !== 8'h00 || core_start !== 1'b0 || core_stop !== 1'b0 ||
        job_midstate !== '0 || job_tail !== '0) begin
      errors++;
      $display("FAIL reset_values: req=%b state=%0d v=%b b=%h st=%b sp=%b", request_job,
               current_fsm_state, tx_valid, tx_byte, core_start, core_stop);
    end
    for (int i = 0; i < NC; i++) begin
      exp_base = 32'((64'h1_0000_0000 / NC) * i);
      checks++;
      if (core_nonce_base[i*32 +: 32] !== exp_base) begin
        errors++;
        $display("FAIL nonce_base[%0d]: got %h want %h", i, core_nonce_base[i*32 +: 32], exp_base);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (current_fsm_state !== 3'd0 || request_job !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d req=%b want 0 1", current_fsm_state, request_job);
    end
  endtask

  task automatic test_dispatch();
    load_job(0, 1'b1);
    checks++;
    if (job_midstate[255:248] !== 8'h00 || job_tail[7:0] !== 8'h2B) begin
      errors++;
      $display("FAIL seq_job_ends: first=%h last=%h want 00 2b", job_midstate[255:248], job_tail[7:0]);
    end
  endtask

  task automatic test_found();
    logic [NC-1:0] iso;
    logic [31:0]   nonces [NC];
    int            win;
    // A partial done mask here must not leak into the next job.
    core_done = 4'b1010;
    tick();
    core_done = '0;
    checks++;
    if (current_fsm_state !== 3'd3 || core_stop !== 1'b0) begin
      errors++;
      $display("FAIL partial_done: state=%0d stop=%b want 3 0", current_fsm_state, core_stop);
    end
    for (int i = 0; i < NC; i++) nonces[i] = $urandom;
    nonces[1] = 32'h4000_1234;
    nonces[2] = 32'h8000_0001;
    for (int i = 0; i < NC; i++) core_nonce[i*32 +: 32] = nonces[i];
    core_found = 4'b0110;
    iso = core_found & (~core_found + 4'd1);
    win = $clog2(iso);
    tick();
    core_found = '0;
    checks++;
    if (core_stop !== 1'b1 || tx_valid !== 1'b1 || tx_byte !== 8'hA5 || current_fsm_state !== 3'd4) begin
      errors++;
      $display("FAIL found_response: stop=%b v=%b b=%h state=%0d want 1 1 a5 4",
               core_stop, tx_valid, tx_byte, current_fsm_state);
    end
    tx_ready = 1'b0;
    tick();
    checks++;
    if (core_stop !== 1'b0 || tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL stop_single_pulse: stop=%b b=%h want 0 a5", core_stop, tx_byte);
    end
    recv_frame({8'hA5, nonces[win]}, 1'b0);
  endtask

  task automatic test_exhaust();
    logic [NC-1:0] seq_d [3];
    logic [NC-1:0] mask_m = '0;
    logic [2:0]    exp_state;
    seq_d[0] = 4'b0001;
    seq_d[1] = 4'b0100;
    seq_d[2] = 4'b1010;
    load_job(0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      core_done = seq_d[s];
      mask_m |= seq_d[s];
      exp_state = (mask_m == '1) ? 3'd4 : 3'd3;
      tick();
      core_done = '0;
      checks++;
      if (current_fsm_state !== exp_state || tx_valid !== (exp_state == 3'd4)) begin
        errors++;
        $display("FAIL exhaust_step%0d: state=%0d v=%b want state %0d", s, current_fsm_state, tx_valid, exp_state);
      end
    end
    checks++;
    if (tx_byte !== 8'h5A || core_stop !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_status: b=%h stop=%b want 5a 0", tx_byte, core_stop);
    end
    // Host traffic during SEND is ignored.
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_abort = 1'b1;
    rx_byte  = 8'hEE;
    tick();
    tick();
    rx_valid = 1'b0;
    rx_abort = 1'b0;
    checks++;
    if (current_fsm_state !== 3'd4 || tx_byte !== 8'h5A || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL send_ignores_rx: state=%0d b=%h v=%b want 4 5a 1", current_fsm_state, tx_byte, tx_valid);
    end
    recv_frame({8'h5A, 32'h0}, 1'b0);
  endtask

  task automatic test_abort_and_random_ready();
    logic [NC-1:0] f;
    logic [31:0]   nonces [NC];
    logic [NC-1:0] iso;
    for (int k = 0; k < 20; k++) begin
      job_m[k] = 8'($urandom);
      send_byte(job_m[k]);
    end
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    checks++;
    if (current_fsm_state !== 3'd0 || request_job !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: state=%0d req=%b want 0 1", current_fsm_state, request_job);
    end
    checks++;
    if ({job_midstate, job_tail} !== job_flat()) begin
      errors++;
      $display("FAIL abort_partial_job: got %h want %h", {job_midstate, job_tail}, job_flat());
    end
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    checks++;
    if (current_fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL abort_in_idle: state=%0d want 0", current_fsm_state);
    end
    load_job(0, 1'b0);
    f = 4'($urandom_range(1, 15));
    for (int i = 0; i < NC; i++) begin
      nonces[i] = $urandom;
      core_nonce[i*32 +: 32] = nonces[i];
    end
    iso = f & (~f + 4'd1);
    core_found = f;
    tick();
    core_found = '0;
    recv_frame({8'hA5, nonces[$clog2(iso)]}, 1'b1);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 10; k++) begin
      job_m[k] = 8'($urandom);
      send_byte(job_m[k]);
    end
    repeat (TO - 1) tick();
    checks++;
    if (current_fsm_state !== 3'd1) begin
      errors++;
      $display("FAIL gap_below_timeout: state=%0d want 1", current_fsm_state);
    end
    job_m[10] = 8'($urandom);
    send_byte(job_m[10]);
    repeat (TO + 1) tick();
    checks++;
    if (current_fsm_state !== 3'd0 || request_job !== 1'b1) begin
      errors++;
      $display("FAIL gap_timeout: state=%0d req=%b want 0 1", current_fsm_state, request_job);
    end
  endtask

  task automatic test_preempt_and_async_reset();
    logic [7:0] b;
    load_job(0, 1'b0);
    b = 8'($urandom);
    job_m[0] = b;
    send_byte(b);
    checks++;
    if (core_stop !== 1'b1 || current_fsm_state !== 3'd1) begin
      errors++;
      $display("FAIL preempt: stop=%b state=%0d want 1 1", core_stop, current_fsm_state);
    end
    // Dispatch after exactly 43 more bytes proves the count restarted at 1.
    load_job(1, 1'b0);
    core_nonce[3*32 +: 32] = $urandom;
    core_found = 4'b1000;
    tick();
    core_found = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    checks++;
    if (current_fsm_state !== 3'd4 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_send: state=%0d v=%b want 4 1", current_fsm_state, tx_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || request_job !== 1'b1 || current_fsm_state !== 3'd0 ||
        tx_byte !== 8'h00 || core_stop !== 1'b0 || job_midstate !== '0 || job_tail !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%b req=%b state=%0d b=%h", tx_valid, request_job, current_fsm_state, tx_byte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = '0;
    rx_abort   = 1'b0;
    tx_ready   = 1'b0;
    core_found = '0;
    core_nonce = '0;
    core_done  = '0;
    for (int k = 0; k < 44; k++) job_m[k] = '0;
    test_reset();
    test_dispatch();
    test_found();
    test_exhaust();
    test_abort_and_random_ready();
    test_timeout();
    test_preempt_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
